// File: rtl/condicionador_botao.sv
// condicionador_botao
// Conditions the raw pedestrian push-button for the traffic-light controller.
// The block has three stages:
//   1. a two-flop synchronizer on the asynchronous pin,
//   2. a debounce FSM that confirms presses and releases,
//   3. registered outputs: a single-cycle press pulse, the debounced level
//      and a wrapping 8-bit press counter.
// Every output comes straight from a flop, so there is no combinational
// path from the pin to any output.

module condicionador_botao #(
   parameter int DEBOUNCE_CYCLES = 4   // legal range 1..255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_bruto,
   output logic       botao,
   output logic       pressionado,
   output logic [7:0] contagem_apertos
);

   typedef enum logic [1:0] {
      SOLTO        = 2'd0,
      CONF_APERTO  = 2'd1,
      APERTADO     = 2'd2,
      CONF_SOLTURA = 2'd3
   } estado_t;

   // Last counter value before a press or release is confirmed.
   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   estado_t    estado_q;
   logic       s1_q;
   logic       s2_q;
   logic [7:0] cnt_q;
   logic       botao_q;
   logic       pressionado_q;
   logic [7:0] contagem_q;

   // Synchronizer, debounce FSM and registered outputs, all with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q      <= SOLTO;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         cnt_q         <= 8'd0;
         botao_q       <= 1'b0;
         pressionado_q <= 1'b0;
         contagem_q    <= 8'd0;
      end else begin
         s1_q    <= botao_bruto;
         s2_q    <= s1_q;
         // The pulse lasts one cycle: it is cleared here unless the
         // confirming transition below sets it again.
         botao_q <= 1'b0;

         case (estado_q)
            SOLTO: begin
               if (s2_q) begin
                  estado_q <= CONF_APERTO;
                  cnt_q    <= 8'd0;
               end else begin
                  estado_q <= SOLTO;
               end
            end

            CONF_APERTO: begin
               if (!s2_q) begin
                  estado_q <= SOLTO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q      <= APERTADO;
                  botao_q       <= 1'b1;
                  pressionado_q <= 1'b1;
                  contagem_q    <= contagem_q + 8'd1;   // wraps 255 -> 0
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            APERTADO: begin
               if (!s2_q) begin
                  estado_q <= CONF_SOLTURA;
                  cnt_q    <= 8'd0;
               end else begin
                  estado_q <= APERTADO;
               end
            end

            CONF_SOLTURA: begin
               // Release bounce returns to APERTADO without a new pulse.
               if (s2_q) begin
                  estado_q <= APERTADO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q      <= SOLTO;
                  pressionado_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            default: begin
               estado_q      <= SOLTO;
               cnt_q         <= 8'd0;
               pressionado_q <= 1'b0;
            end
         endcase
      end
   end

   assign botao            = botao_q;
   assign pressionado      = pressionado_q;
   assign contagem_apertos = contagem_q;

endmodule

// File: tb/tb_condicionador_botao.sv
// Directed testbench for condicionador_botao with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so "after edge k" means the value visible following that edge.

module tb_condicionador_botao;

   logic       clock;
   logic       reset;
   logic       botao_bruto;
   logic       botao;
   logic       pressionado;
   logic [7:0] contagem_apertos;

   int total;
   int bad;
   int pulses;
   logic prev_botao;

   condicionador_botao #(.DEBOUNCE_CYCLES(4)) dut (
      .clock            (clock),
      .reset            (reset),
      .botao_bruto      (botao_bruto),
      .botao            (botao),
      .pressionado      (pressionado),
      .contagem_apertos (contagem_apertos)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold botao_bruto at lvl for n edges, counting pulses and checking width.
   task automatic run(input logic lvl, input int n);
      botao_bruto = lvl;
      for (int i = 0; i < n; i++) begin
         tick();
         if (botao === 1'b1) pulses++;
         check("pulse_width", {7'd0, botao & prev_botao}, 8'd0);
         prev_botao = botao;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      botao_bruto = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      prev_botao = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      pulses = 0;
      prev_botao = 1'b0;
      reset = 1'b1;
      botao_bruto = 1'b0;

      // Reset values and 20 idle cycles.
      do_reset();
      check("rst_botao", {7'd0, botao}, 8'd0);
      check("rst_press", {7'd0, pressionado}, 8'd0);
      check("rst_count", contagem_apertos, 8'd0);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("idle_botao", {7'd0, botao}, 8'd0);
         check("idle_press", {7'd0, pressionado}, 8'd0);
         check("idle_count", contagem_apertos, 8'd0);
      end

      // Button held 50 cycles; first sampled high at edge 0.
      botao_bruto = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         check("hold_botao", {7'd0, botao}, (k == 6) ? 8'd1 : 8'd0);
         check("hold_press", {7'd0, pressionado}, (k >= 6) ? 8'd1 : 8'd0);
      end
      check("hold_count", contagem_apertos, 8'd1);

      // Release bounce 1,0,1,0,1 then stable 0 (first stable low at edge 5).
      for (int e = 0; e < 20; e++) begin
         botao_bruto = (e < 5) ? ((e % 2) == 0) : 1'b0;
         tick();
         check("rel_press", {7'd0, pressionado}, (e < 11) ? 8'd1 : 8'd0);
         check("rel_botao", {7'd0, botao}, 8'd0);
      end
      check("rel_count", contagem_apertos, 8'd1);

      // Glitches of 1, 3 and 4 high samples are rejected; 5 is accepted.
      do_reset();
      pulses = 0;
      run(1'b0, 10);
      run(1'b1, 1);
      run(1'b0, 10);
      run(1'b1, 3);
      run(1'b0, 10);
      run(1'b1, 4);
      run(1'b0, 10);
      check("glitch_pulses", 8'(pulses), 8'd0);
      check("glitch_count", contagem_apertos, 8'd0);
      run(1'b1, 5);
      run(1'b0, 15);
      check("five_pulses", 8'(pulses), 8'd1);
      check("five_count", contagem_apertos, 8'd1);

      // 257 clean presses: counter wraps after the 256th.
      do_reset();
      pulses = 0;
      for (int p = 1; p <= 257; p++) begin
         run(1'b1, 10);
         run(1'b0, 10);
         if (p == 255) check("count_255", contagem_apertos, 8'd255);
         if (p == 256) check("count_wrap", contagem_apertos, 8'd0);
      end
      check("count_257", contagem_apertos, 8'd1);
      check("pulses_257", 8'(pulses - 256), 8'd1);

      // Reset sampled at edge 4 of a press (inside CONF_APERTO), input held high.
      do_reset();
      run(1'b0, 5);
      botao_bruto = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("pre_rst_botao", {7'd0, botao}, 8'd0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_botao", {7'd0, botao}, 8'd0);
      check("midrst_press", {7'd0, pressionado}, 8'd0);
      check("midrst_count", contagem_apertos, 8'd0);
      for (int k = 5; k < 25; k++) begin
         tick();
         check("redo_botao", {7'd0, botao}, (k == 11) ? 8'd1 : 8'd0);
         check("redo_press", {7'd0, pressionado}, (k >= 11) ? 8'd1 : 8'd0);
      end
      check("redo_count", contagem_apertos, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
